// File: rtl/fetch_sequencer.sv
// Fetch-stage controller: sequences the external ProgramCounter, runs the imem
// request/ready handshake and holds one fetched instruction for decode.
module fetch_sequencer #(
    parameter int unsigned         WORD_LEN     = 32,
    parameter logic [WORD_LEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [WORD_LEN-1:0] EXC_VECTOR   = 32'h0000_0080,
    parameter int unsigned         TIMEOUT      = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [WORD_LEN-1:0] pc,
    output logic                pc_enable,
    output logic [WORD_LEN-1:0] pc_next,
    output logic                imem_req,
    output logic [WORD_LEN-1:0] imem_addr,
    input  logic                imem_ready,
    input  logic [WORD_LEN-1:0] imem_rdata,
    output logic [WORD_LEN-1:0] instr,
    output logic [WORD_LEN-1:0] instr_pc,
    output logic                instr_valid,
    input  logic                id_stall,
    input  logic                branch_taken,
    input  logic [WORD_LEN-1:0] branch_target,
    input  logic                jump,
    input  logic [WORD_LEN-1:0] jump_target,
    input  logic                exception,
    output logic                fetch_error
);

    localparam int unsigned         CNT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0]    CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [WORD_LEN-1:0] PC_STEP  = WORD_LEN'(32'd4);
    localparam logic [WORD_LEN-1:0] ZERO_W   = {WORD_LEN{1'b0}};

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_ERROR = 2'd3
    } state_t;

    state_t              state_r;
    logic                outstanding_r;
    logic [WORD_LEN-1:0] req_addr_r;
    logic [CNT_W-1:0]    wait_cnt_r;

    logic                redirect_s;
    logic [WORD_LEN-1:0] target_s;
    logic [WORD_LEN-1:0] seq_pc_s;
    logic                slot_busy_s;
    logic                consumed_s;
    logic                req_s;
    logic [WORD_LEN-1:0] addr_s;
    logic                pc_en_s;
    logic [WORD_LEN-1:0] pc_next_s;
    logic                wait_s;
    logic                done_s;
    logic                timeout_s;

    // Redirect priority and decode-slot status
    always_comb begin
        redirect_s  = exception | branch_taken | jump;
        seq_pc_s    = pc + PC_STEP;
        slot_busy_s = instr_valid & id_stall;
        consumed_s  = instr_valid & ~id_stall;
        if (exception) begin
            target_s = EXC_VECTOR;
        end else if (branch_taken) begin
            target_s = branch_target;
        end else begin
            target_s = jump_target;
        end
    end

    // Memory request and PC update driven from the current state
    always_comb begin
        req_s     = 1'b0;
        addr_s    = ZERO_W;
        pc_en_s   = 1'b0;
        pc_next_s = seq_pc_s;
        if (reset) begin
            pc_next_s = ZERO_W;
        end else begin
            case (state_r)
                ST_BOOT: begin
                    pc_en_s   = 1'b1;
                    pc_next_s = RESET_VECTOR;
                end
                ST_FETCH: begin
                    // A live request keeps its latched address even though pc may differ
                    if (outstanding_r) begin
                        req_s  = 1'b1;
                        addr_s = req_addr_r;
                    end else if (!slot_busy_s) begin
                        req_s  = 1'b1;
                        addr_s = pc;
                    end else begin
                        req_s  = 1'b0;
                        addr_s = pc;
                    end
                    if (redirect_s) begin
                        pc_en_s   = 1'b1;
                        pc_next_s = target_s;
                    end else if (req_s && imem_ready) begin
                        pc_en_s   = 1'b1;
                        pc_next_s = seq_pc_s;
                    end else begin
                        pc_en_s   = 1'b0;
                        pc_next_s = seq_pc_s;
                    end
                end
                ST_DRAIN: begin
                    req_s  = 1'b1;
                    addr_s = req_addr_r;
                    if (redirect_s) begin
                        pc_en_s   = 1'b1;
                        pc_next_s = target_s;
                    end else begin
                        pc_en_s   = 1'b0;
                        pc_next_s = seq_pc_s;
                    end
                end
                ST_ERROR: begin
                    req_s = 1'b0;
                end
                default: begin
                    req_s = 1'b0;
                end
            endcase
        end
    end

    assign wait_s    = req_s & ~imem_ready;
    assign done_s    = req_s & imem_ready;
    assign timeout_s = wait_s & (wait_cnt_r == CNT_LAST);

    assign pc_enable = pc_en_s;
    assign pc_next   = pc_next_s;
    assign imem_req  = req_s;
    assign imem_addr = addr_s;

    // Sequencer state, wait counter and the decode instruction slot
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_BOOT;
            outstanding_r <= 1'b0;
            req_addr_r    <= ZERO_W;
            wait_cnt_r    <= CNT_ZERO;
            instr         <= ZERO_W;
            instr_pc      <= ZERO_W;
            instr_valid   <= 1'b0;
            fetch_error   <= 1'b0;
        end else begin
            if (wait_s && !timeout_s) begin
                wait_cnt_r <= wait_cnt_r + CNT_ONE;
            end else if (done_s) begin
                wait_cnt_r <= CNT_ZERO;
            end else begin
                wait_cnt_r <= wait_cnt_r;
            end

            if (timeout_s) begin
                state_r       <= ST_ERROR;
                fetch_error   <= 1'b1;
                instr_valid   <= 1'b0;
                outstanding_r <= 1'b0;
            end else begin
                case (state_r)
                    ST_BOOT: begin
                        state_r <= ST_FETCH;
                    end
                    ST_FETCH: begin
                        if (redirect_s) begin
                            // Flush; a read already on the bus must be absorbed in DRAIN
                            instr_valid   <= 1'b0;
                            outstanding_r <= 1'b0;
                            if (wait_s) begin
                                state_r    <= ST_DRAIN;
                                req_addr_r <= addr_s;
                            end
                        end else if (done_s) begin
                            instr         <= imem_rdata;
                            instr_pc      <= addr_s;
                            instr_valid   <= 1'b1;
                            outstanding_r <= 1'b0;
                        end else begin
                            if (consumed_s) begin
                                instr_valid <= 1'b0;
                            end
                            if (wait_s) begin
                                outstanding_r <= 1'b1;
                                req_addr_r    <= addr_s;
                            end
                        end
                    end
                    ST_DRAIN: begin
                        instr_valid <= 1'b0;
                        if (done_s) begin
                            state_r <= ST_FETCH;
                        end
                    end
                    ST_ERROR: begin
                        instr_valid <= 1'b0;
                    end
                    default: begin
                        state_r <= ST_BOOT;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: expected decode words are queued as
// stimulus is issued and popped by a monitor on every consumption.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc = 32'hDEAD_BEE0;
    logic        pc_enable;
    logic [31:0] pc_next;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        id_stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        exception;
    logic        fetch_error;

    int          total = 0;
    int          bad = 0;
    logic [63:0] exp_q[$];
    logic [63:0] mon_exp;

    fetch_sequencer #(
        .WORD_LEN(32),
        .RESET_VECTOR(32'h0000_0000),
        .EXC_VECTOR(32'h0000_0080),
        .TIMEOUT(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .pc(pc),
        .pc_enable(pc_enable),
        .pc_next(pc_next),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ready(imem_ready),
        .imem_rdata(imem_rdata),
        .instr(instr),
        .instr_pc(instr_pc),
        .instr_valid(instr_valid),
        .id_stall(id_stall),
        .branch_taken(branch_taken),
        .branch_target(branch_target),
        .jump(jump),
        .jump_target(jump_target),
        .exception(exception),
        .fetch_error(fetch_error)
    );

    always #5 clk = ~clk;

    // ProgramCounter register model
    always @(posedge clk) begin
        if (pc_enable) pc <= pc_next;
    end

    // Memory returns the inverted address so instr and instr_pc are distinguishable
    assign imem_rdata = ~imem_addr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_instr(input logic [31:0] a);
        exp_q.push_back({a, ~a});
    endtask

    // Monitor: every consumed instruction must match the head of the queue
    always @(negedge clk) begin
        #2;
        if (!reset && instr_valid === 1'b1 && id_stall === 1'b0) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_extra: got pc=%h instr=%h expected nothing", instr_pc, instr);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({instr_pc, instr} !== mon_exp) begin
                    bad++;
                    $display("FAIL sb_instr: got pc=%h instr=%h expected pc=%h instr=%h",
                             instr_pc, instr, mon_exp[63:32], mon_exp[31:0]);
                end
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; imem_ready = 1'b1; id_stall = 1'b0;
        branch_taken = 1'b0; branch_target = 32'h0; jump = 1'b0; jump_target = 32'h0;
        exception = 1'b0;

        // 1: reset, BOOT, back-to-back zero-wait fetches
        repeat (3) @(negedge clk);
        #1;
        check("rst_pc_enable", 32'(pc_enable), 32'h0);
        check("rst_pc_next", pc_next, 32'h0);
        check("rst_imem_req", 32'(imem_req), 32'h0);
        check("rst_imem_addr", imem_addr, 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_instr_pc", instr_pc, 32'h0);
        check("rst_instr_valid", 32'(instr_valid), 32'h0);
        check("rst_fetch_error", 32'(fetch_error), 32'h0);
        expect_instr(32'h0); expect_instr(32'h4); expect_instr(32'h8); expect_instr(32'hC);
        reset = 1'b0;
        #1;
        check("boot_pc_enable", 32'(pc_enable), 32'h1);
        check("boot_pc_next", pc_next, 32'h0);
        check("boot_imem_req", 32'(imem_req), 32'h0);
        @(negedge clk); #1;
        check("fetch0_req", 32'(imem_req), 32'h1);
        check("fetch0_addr", imem_addr, 32'h0);
        check("fetch0_pc_next", pc_next, 32'h4);

        // 2: decode stall freezes the slot and the PC
        @(negedge clk); @(negedge clk);
        @(negedge clk); id_stall = 1'b1; #1;
        check("stall_req", 32'(imem_req), 32'h0);
        check("stall_pc_enable", 32'(pc_enable), 32'h0);
        check("stall_instr_pc", instr_pc, 32'h8);
        @(negedge clk); #1;
        check("stall2_instr_pc", instr_pc, 32'h8);
        check("stall2_instr", instr, 32'hFFFF_FFF7);
        check("stall2_pc", pc, 32'hC);
        check("stall2_req", 32'(imem_req), 32'h0);
        @(negedge clk); id_stall = 1'b0;

        // 3: redirect priority
        @(negedge clk);
        branch_taken = 1'b1; branch_target = 32'h100; jump = 1'b1; jump_target = 32'h200; #1;
        check("br_pc_enable", 32'(pc_enable), 32'h1);
        check("br_pc_next", pc_next, 32'h100);
        expect_instr(32'h100);
        @(negedge clk); branch_taken = 1'b0; jump = 1'b0; #1;
        check("br_pc", pc, 32'h100);
        check("br_flush", 32'(instr_valid), 32'h0);
        @(negedge clk);
        exception = 1'b1; branch_taken = 1'b1; jump = 1'b1; #1;
        check("exc_pc_next", pc_next, 32'h80);
        expect_instr(32'h80);
        @(negedge clk); exception = 1'b0; branch_taken = 1'b0; jump = 1'b0; #1;
        check("exc_pc", pc, 32'h80);
        check("exc_flush", 32'(instr_valid), 32'h0);

        // 4: branch during a wait drops the in-flight word
        @(negedge clk); imem_ready = 1'b0; #1;
        check("w1_req", 32'(imem_req), 32'h1);
        check("w1_addr", imem_addr, 32'h84);
        @(negedge clk); branch_taken = 1'b1; branch_target = 32'h40; #1;
        check("w2_addr", imem_addr, 32'h84);
        check("w2_pc_next", pc_next, 32'h40);
        @(negedge clk); branch_taken = 1'b0; #1;
        check("w3_req", 32'(imem_req), 32'h1);
        check("w3_addr", imem_addr, 32'h84);
        check("w3_pc_enable", 32'(pc_enable), 32'h0);
        check("w3_valid", 32'(instr_valid), 32'h0);
        check("w3_pc", pc, 32'h40);
        @(negedge clk); imem_ready = 1'b1; #1;
        check("drain_done_addr", imem_addr, 32'h84);
        check("drain_done_pc_enable", 32'(pc_enable), 32'h0);
        expect_instr(32'h40);
        @(negedge clk); #1;
        check("refetch_req", 32'(imem_req), 32'h1);
        check("refetch_addr", imem_addr, 32'h40);

        // 5: memory never ready -> sticky fetch_error after 16 waits
        @(negedge clk); imem_ready = 1'b0;
        repeat (15) @(negedge clk);
        #1;
        check("to_before_err", 32'(fetch_error), 32'h0);
        check("to_before_req", 32'(imem_req), 32'h1);
        check("to_before_addr", imem_addr, 32'h44);
        @(negedge clk); #1;
        check("err_flag", 32'(fetch_error), 32'h1);
        check("err_req", 32'(imem_req), 32'h0);
        check("err_pc_enable", 32'(pc_enable), 32'h0);
        check("err_valid", 32'(instr_valid), 32'h0);
        imem_ready = 1'b1; exception = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("err_sticky", 32'(fetch_error), 32'h1);
        check("err_ignore_pc_enable", 32'(pc_enable), 32'h0);
        check("err_ignore_req", 32'(imem_req), 32'h0);
        @(negedge clk); exception = 1'b0; reset = 1'b1; #1;
        check("rr_req", 32'(imem_req), 32'h0);
        check("rr_pc_enable", 32'(pc_enable), 32'h0);
        @(negedge clk); #1;
        check("rr_err_clear", 32'(fetch_error), 32'h0);
        check("rr_valid", 32'(instr_valid), 32'h0);
        reset = 1'b0; #1;
        check("boot2_pc_enable", 32'(pc_enable), 32'h1);
        check("boot2_pc_next", pc_next, 32'h0);

        // 6: PC wrap, then reset while draining
        @(negedge clk); jump = 1'b1; jump_target = 32'hFFFF_FFFC; #1;
        check("wrap_jump_next", pc_next, 32'hFFFF_FFFC);
        expect_instr(32'hFFFF_FFFC);
        @(negedge clk); jump = 1'b0; #1;
        check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        check("wrap_pc_enable", 32'(pc_enable), 32'h1);
        check("wrap_pc_next", pc_next, 32'h0);
        @(negedge clk); imem_ready = 1'b0; #1;
        check("wrap2_addr", imem_addr, 32'h0);
        @(negedge clk); branch_taken = 1'b1; branch_target = 32'h200; #1;
        check("drain_entry_next", pc_next, 32'h200);
        @(negedge clk); branch_taken = 1'b0; #1;
        check("drain_req", 32'(imem_req), 32'h1);
        check("drain_addr", imem_addr, 32'h0);
        reset = 1'b1; #1;
        check("mid_rst_req", 32'(imem_req), 32'h0);
        check("mid_rst_addr", imem_addr, 32'h0);
        check("mid_rst_pc_enable", 32'(pc_enable), 32'h0);
        check("mid_rst_pc_next", pc_next, 32'h0);
        @(negedge clk); #1;
        check("mid_rst_instr", instr, 32'h0);
        check("mid_rst_instr_pc", instr_pc, 32'h0);
        check("mid_rst_valid", 32'(instr_valid), 32'h0);
        check("mid_rst_err", 32'(fetch_error), 32'h0);
        reset = 1'b0; imem_ready = 1'b1; #1;
        check("boot3_pc_enable", 32'(pc_enable), 32'h1);
        check("boot3_pc_next", pc_next, 32'h0);
        check("boot3_req", 32'(imem_req), 32'h0);
        expect_instr(32'h0);
        @(negedge clk); #1;
        check("boot3_fetch_addr", imem_addr, 32'h0);
        @(negedge clk); imem_ready = 1'b0;
        repeat (3) @(negedge clk);
        #3;
        check("sb_left", 32'(exp_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
